// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder/subtractor controller.
`timescale 1ps/1ps
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bit-counter width for a WIDTH-cycle run; never less than one bit.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// One-bit full adder used as the serial datapath slice.
`timescale 1ps/1ps
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one result bit per RUN cycle, LSB first,
// through a single full_adder; registered result and flags held between operations.
`timescale 1ps/1ps
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int              CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_sr_reg, b_sr_reg;
    logic [WIDTH-2:0]   res_sr_reg;
    logic               carry_reg;
    logic [CW-1:0]      cnt_reg;
    logic               a_msb_reg, b_msb_reg;
    logic [WIDTH-1:0]   sum_reg;
    logic               carry_out_reg, overflow_reg, zero_reg;

    logic               fa_s, fa_cout;
    logic               load, run, last;
    logic [WIDTH-1:0]   res_shift;

    full_adder u_fa (
        .a    (a_sr_reg[0]),
        .b    (b_sr_reg[0]),
        .cin  (carry_reg),
        .s    (fa_s),
        .cout (fa_cout)
    );

    assign load = (state_reg == IDLE) && start;
    assign run  = (state_reg == RUN);
    assign last = run && (cnt_reg == LAST);

    // New bit enters at the MSB; on the last edge this is the complete result.
    assign res_shift = {fa_s, res_sr_reg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sr_reg      <= '0;
            b_sr_reg      <= '0;
            res_sr_reg    <= '0;
            carry_reg     <= 1'b0;
            cnt_reg       <= '0;
            a_msb_reg     <= 1'b0;
            b_msb_reg     <= 1'b0;
            sum_reg       <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
            zero_reg      <= 1'b0;
        end else if (load) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with sub.
            a_sr_reg   <= a;
            b_sr_reg   <= sub ? ~b : b;
            carry_reg  <= sub;
            cnt_reg    <= '0;
            a_msb_reg  <= a[WIDTH-1];
            b_msb_reg  <= b[WIDTH-1] ^ sub;
        end else if (run) begin
            res_sr_reg <= res_shift[WIDTH-1:1];
            a_sr_reg   <= a_sr_reg >> 1;
            b_sr_reg   <= b_sr_reg >> 1;
            carry_reg  <= fa_cout;
            if (last) begin
                sum_reg       <= res_shift;
                carry_out_reg <= fa_cout;
                overflow_reg  <= (a_msb_reg == b_msb_reg) && (fa_s != a_msb_reg);
                zero_reg      <= (res_shift == '0);
            end else begin
                // Held at WIDTH-1 on the exit edge so the counter never wraps.
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign busy      = (state_reg == RUN);
    assign done      = (state_reg == DONE);
    assign sum       = sum_reg;
    assign carry_out = carry_out_reg;
    assign overflow  = overflow_reg;
    assign zero      = zero_reg;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8: directed table,
// multi-cycle corner sequences and random operations against an arithmetic model.
`timescale 1ps/1ps
module tb_serial_adder_ctrl;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             sub = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy, done, carry_out, overflow, zero;
    logic [WIDTH-1:0] sum;

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] prev_sum = '0;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #500 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sub;
        logic [7:0] s;
        logic       c;
        logic       v;
        logic       z;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    // busy and done are mutually exclusive in every cycle.
    always @(negedge clk) begin
        if (!reset) begin
            total++;
            if (busy && done) begin
                bad++;
                $display("FAIL busy_done_overlap: got busy=1 done=1 want not both");
            end
        end
    end

    // Plain integer arithmetic; carry_out for subtraction means "no borrow".
    function automatic void model(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                                  output logic [7:0] s, output logic c, output logic v,
                                  output logic z);
        int ua, ub, ur, ia, ib, ir;
        ua = int'(av);
        ub = int'(bv);
        ia = int'($signed(av));
        ib = int'($signed(bv));
        ur = sv ? (ua - ub) : (ua + ub);
        ir = sv ? (ia - ib) : (ia + ib);
        s  = ur[7:0];
        c  = sv ? (ua >= ub) : (ur > 255);
        v  = (ir > 127) || (ir < -128);
        z  = (s == 8'h00);
    endfunction

    task automatic check_all_zero(input string nm);
        check({nm, "_busy"}, 64'(busy), 64'd0);
        check({nm, "_done"}, 64'(done), 64'd0);
        check({nm, "_sum"},  64'(sum), 64'd0);
        check({nm, "_cout"}, 64'(carry_out), 64'd0);
        check({nm, "_ovf"},  64'(overflow), 64'd0);
        check({nm, "_zero"}, 64'(zero), 64'd0);
    endtask

    // Issue one operation, optionally hammering start/operands while busy,
    // and check latency, single done pulse, held result and final outputs.
    task automatic run_op(input string nm, input logic [7:0] av, input logic [7:0] bv,
                          input logic sv, input logic [7:0] es, input logic ec,
                          input logic ev, input logic ez, input bit poke);
        int lat, ndone;
        @(negedge clk);
        a = av; b = bv; sub = sv; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({nm, "_busy_after_start"}, 64'(busy), 64'd1);
        lat = 0;
        ndone = 0;
        for (int n = 1; n <= WIDTH + 4; n++) begin
            if (poke && lat == 0) begin
                start = n[0];
                a = 8'h33; b = 8'h33; sub = ~sv;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                ndone++;
                if (lat == 0) begin
                    lat = n;
                    check({nm, "_sum"},  64'(sum), 64'(es));
                    check({nm, "_cout"}, 64'(carry_out), 64'(ec));
                    check({nm, "_ovf"},  64'(overflow), 64'(ev));
                    check({nm, "_zero"}, 64'(zero), 64'(ez));
                    $display("op %s a=%h b=%h sub=%b sum=%h c=%b v=%b z=%b lat=%0d",
                             nm, av, bv, sv, sum, carry_out, overflow, zero, n);
                end
            end else if (lat == 0 && busy) begin
                check({nm, "_hold"}, 64'(sum), 64'(prev_sum));
            end
        end
        start = 1'b0;
        if (lat == 0) begin
            bad++;
            total++;
            $display("FAIL %s_timeout: got no done within %0d cycles want done", nm, WIDTH + 4);
        end else begin
            check({nm, "_latency"}, 64'(lat), 64'(WIDTH));
        end
        check({nm, "_done_count"}, 64'(ndone), 64'd1);
        check({nm, "_idle_after"}, 64'(busy), 64'd0);
        prev_sum = es;
    endtask

    initial begin
        logic [7:0] ra, rb, es;
        logic       rs, ec, ev, ez;

        vecs[0] = '{a: 8'h0F, b: 8'h01, sub: 1'b0, s: 8'h10, c: 1'b0, v: 1'b0, z: 1'b0};
        vecs[1] = '{a: 8'hFF, b: 8'h01, sub: 1'b0, s: 8'h00, c: 1'b1, v: 1'b0, z: 1'b1};
        vecs[2] = '{a: 8'h05, b: 8'h07, sub: 1'b1, s: 8'hFE, c: 1'b0, v: 1'b0, z: 1'b0};
        vecs[3] = '{a: 8'h7F, b: 8'h01, sub: 1'b0, s: 8'h80, c: 1'b0, v: 1'b1, z: 1'b0};
        vecs[4] = '{a: 8'h10, b: 8'h10, sub: 1'b1, s: 8'h00, c: 1'b1, v: 1'b0, z: 1'b1};
        vecs[5] = '{a: 8'h80, b: 8'h01, sub: 1'b1, s: 8'h7F, c: 1'b1, v: 1'b1, z: 1'b0};

        // Reset state.
        #1200;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Directed table; first op also exercises the first edge after reset.
        for (int i = 0; i < 6; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                   vecs[i].s, vecs[i].c, vecs[i].v, vecs[i].z, 1'b0);
        end

        // Start pulses while busy must be ignored.
        run_op("busy_start", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1);

        // Abort mid-run: outputs clear at once and no done follows.
        @(negedge clk);
        a = 8'h5A; b = 8'h11; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_busy_before", 64'(busy), 64'd1);
        #200;
        reset = 1'b1;
        #1;
        check_all_zero("abort");
        @(negedge clk);
        reset = 1'b0;
        for (int n = 0; n < WIDTH + 2; n++) begin
            @(negedge clk);
            check("abort_no_done", 64'(done), 64'd0);
        end
        check("abort_idle", 64'(busy), 64'd0);
        prev_sum = '0;
        $display("op abort sum=%h busy=%b", sum, busy);

        run_op("after_abort", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0);

        // Random operations against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            model(ra, rb, rs, es, ec, ev, ez);
            run_op($sformatf("rnd%0d", i), ra, rb, rs, es, ec, ev, ez, (i % 5) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #5000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 The block SHALL have a parameter: WIDTH, 64, operand/result width in bits (legal range 2..64).
REQ-002 The block SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-003 The block SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port: start  input  1  request a new operation; sampled only in IDLE.
REQ-005 The block SHALL have port: sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-006 The block SHALL have ports: a, b  input  WIDTH  operands; sampled with start.
REQ-007 The block SHALL have port: busy  output  1  high while in RUN.
REQ-008 The block SHALL have port: done  output  1  one-cycle pulse, result valid.
REQ-009 The block SHALL have port: sum  output  WIDTH  registered result.
REQ-010 The block SHALL have ports: carry_out, overflow, zero  output  1 each  registered flags.

Function
REQ-011 The FSM SHALL have states IDLE, RUN and DONE.
REQ-012 In IDLE with start=1, the block SHALL, at the edge:
  - load operand shift registers with a and (sub ? ~b : b);
  - load the carry register with sub;
  - clear the bit counter;
  - go to RUN.
REQ-013 Each RUN cycle SHALL feed one full_adder instance with the LSBs of both shift registers and the carry register.
REQ-014 At each RUN edge the block SHALL:
  - shift the adder sum bit into the MSB of the result shift register;
  - shift both operand registers right by one;
  - store the adder carry into the carry register;
  - increment the counter.
REQ-015 RUN SHALL last exactly WIDTH cycles; the edge at which counter==WIDTH-1 SHALL move the FSM to DONE.
REQ-016 On that same edge the block SHALL update the output registers:
  - sum = final result;
  - carry_out = final carry;
  - overflow = (opA[MSB]==opB'[MSB]) && (sum[MSB]!=opA[MSB]), using the MSBs latched at start;
  - zero = (sum==0).
REQ-017 done SHALL be high for exactly the one DONE cycle; the FSM SHALL then return to IDLE unconditionally.
REQ-018 Latency: done SHALL be high in cycle WIDTH+1 when the start edge is cycle 0.
REQ-019 Output registers SHALL hold their values from DONE until the next operation's DONE edge, including throughout the following RUN.
REQ-020 start, sub, a and b SHALL be ignored in RUN and DONE; no queuing.
REQ-021 busy SHALL equal (state==RUN); busy and done SHALL never be high together.
REQ-022 The counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap during RUN.

Reset
REQ-023 reset SHALL asynchronously force the FSM to IDLE and clear all registers, making every output 0: busy, done, sum, carry_out, overflow, zero.
REQ-024 reset during RUN SHALL abort the operation with no done pulse and SHALL clear the previously held result.
REQ-025 After reset deasserts, the first rising edge with start=1 SHALL be accepted.

Structure
REQ-026 Package serial_adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the counter-width helper.
REQ-027 The bit datapath SHALL be one instance of the existing full_adder sub-module; no behavioural '+' SHALL be used.
REQ-028 The clock period SHALL cover the full_adder gate delays; the bench SHALL use a period of 1000 ps.

Verification (WIDTH=8)
REQ-029 Add: a=0x0F, b=0x01, sub=0 -> done in cycle 9; sum=0x10, carry_out=0, overflow=0, zero=0.
REQ-030 Wrap: a=0xFF, b=0x01 -> sum=0x00, carry_out=1, zero=1, overflow=0.
REQ-031 Subtract/overflow:
  - a=0x05, b=0x07, sub=1 -> sum=0xFE, carry_out=0;
  - a=0x7F, b=0x01, sub=0 -> sum=0x80, overflow=1.
REQ-032 Start while busy: start pulses with a=0x33 during RUN -> ignored; result=0x10 from the first operands; exactly one done pulse.
REQ-033 Abort: reset asserted at RUN cycle 4 -> all outputs 0 immediately, no done; a new start then completes normally.
REQ-034 Hold: after DONE, apply a new start -> sum stays at the old value through RUN and updates only at the new DONE edge.
